// File: rtl/led_matrix_scan.sv
// HUB75 scan engine: fetches top/bottom pixel pairs from a synchronous frame RAM, shifts them out,
// latches the row and lights it for a binary-weighted time per bitplane. Define LED_MATRIX_DBUF_EN for double buffering.
module led_matrix_scan #(
  parameter int COL_BITS   = 5,
  parameter int ROW_BITS   = 3,
  parameter int PWM_BITS   = 8,
  parameter int BASE_DELAY = 2,
`ifdef LED_MATRIX_DBUF_EN
  localparam int BUF_W     = 1,
`else
  localparam int BUF_W     = 0,
`endif
  localparam int ADDR_W    = BUF_W + 1 + ROW_BITS + COL_BITS
) (
  input  logic                    led_clk,
  input  logic                    rsi_reset_n,
  input  logic                    enable,
`ifdef LED_MATRIX_DBUF_EN
  input  logic                    buf_sel,
`endif
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [3*PWM_BITS-1:0]   mem_rdata,
  output logic [ROW_BITS-1:0]     demux,
  output logic [2:0]              rgb0,
  output logic [2:0]              rgb1,
  output logic                    rgb_clk,
  output logic                    rgb_stb,
  output logic                    oe_n,
  output logic                    frame_start
);

  localparam int PLANE_W = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1;
  localparam int DLY_W   = PWM_BITS + $clog2(BASE_DELAY + 1);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(PWM_BITS - 1);

  localparam int IDX_IDLE  = 0;
  localparam int IDX_CLK   = 4;
  localparam int IDX_LATCH = 5;
  localparam int IDX_DELAY = 6;

  // One-hot encoding so the panel strobes are straight flop outputs.
  typedef enum logic [6:0] {
    S_IDLE   = 7'b0000001,
    S_RD_TOP = 7'b0000010,
    S_RD_BOT = 7'b0000100,
    S_SHIFT  = 7'b0001000,
    S_CLK    = 7'b0010000,
    S_LATCH  = 7'b0100000,
    S_DELAY  = 7'b1000000
  } state_t;

  state_t               state_q;
  logic [COL_BITS-1:0]  col_q;
  logic [ROW_BITS-1:0]  row_q;
  logic [PLANE_W-1:0]   plane_q;
  logic [DLY_W-1:0]     delay_q;
  logic [ROW_BITS-1:0]  demux_q;
  logic [2:0]           rgb0_q;
  logic [2:0]           rgb1_q;
  logic [ADDR_W-1:0]    addr_q;

  logic [COL_BITS-1:0]  col_inc_d;
  logic [COL_BITS-1:0]  col_top_d;
  logic [ADDR_W-1:0]    addr_top_d;
  logic [ADDR_W-1:0]    addr_bot_d;

  function automatic logic [2:0] plane_bits(input logic [3*PWM_BITS-1:0] px,
                                            input logic [PLANE_W-1:0]    p);
    return {px[2*PWM_BITS + int'(p)], px[PWM_BITS + int'(p)], px[int'(p)]};
  endfunction

  assign col_inc_d = col_q + 1'b1;
  // The next top fetch is issued from CLK, before col_q has advanced.
  assign col_top_d = (state_q == S_CLK) ? col_inc_d : col_q;

`ifdef LED_MATRIX_DBUF_EN
  logic buf_q;
  logic buf_d;

  // Swap buffers only on the frame boundary so a frame is never torn.
  assign buf_d      = frame_start ? buf_sel : buf_q;
  assign addr_top_d = {buf_d, 1'b0, row_q, col_top_d};
  assign addr_bot_d = {buf_q, 1'b1, row_q, col_q};
`else
  assign addr_top_d = {1'b0, row_q, col_top_d};
  assign addr_bot_d = {1'b1, row_q, col_q};
`endif

  assign frame_start = rsi_reset_n & state_q[IDX_IDLE] & enable
                     & (row_q == '0) & (plane_q == PLANE_LAST);

  assign rgb_clk  = state_q[IDX_CLK];
  assign rgb_stb  = state_q[IDX_LATCH];
  assign oe_n     = ~state_q[IDX_DELAY];
  assign mem_addr = addr_q;
  assign demux    = demux_q;
  assign rgb0     = rgb0_q;
  assign rgb1     = rgb1_q;

  always_ff @(posedge led_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      plane_q <= PLANE_LAST;
      delay_q <= '0;
      demux_q <= '0;
      rgb0_q  <= '0;
      rgb1_q  <= '0;
      addr_q  <= '0;
`ifdef LED_MATRIX_DBUF_EN
      buf_q   <= 1'b0;
`endif
    end else begin
`ifdef LED_MATRIX_DBUF_EN
      buf_q <= buf_d;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (enable) begin
            addr_q  <= addr_top_d;
            state_q <= S_RD_TOP;
          end
        end
        S_RD_TOP: begin
          addr_q  <= addr_bot_d;
          state_q <= S_RD_BOT;
        end
        S_RD_BOT: begin
          // RAM returns the top pixel requested in RD_TOP.
          rgb0_q  <= plane_bits(mem_rdata, plane_q);
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          rgb1_q  <= plane_bits(mem_rdata, plane_q);
          state_q <= S_CLK;
        end
        S_CLK: begin
          col_q <= col_inc_d;
          if (&col_q) begin
            state_q <= S_LATCH;
          end else begin
            addr_q  <= addr_top_d;
            state_q <= S_RD_TOP;
          end
        end
        S_LATCH: begin
          demux_q <= row_q;
          delay_q <= DLY_W'(BASE_DELAY) << plane_q;
          state_q <= S_DELAY;
        end
        S_DELAY: begin
          if (delay_q > DLY_W'(1)) begin
            delay_q <= delay_q - 1'b1;
          end else begin
            delay_q <= '0;
            state_q <= S_IDLE;
            if (plane_q == '0) begin
              plane_q <= PLANE_LAST;
              row_q   <= row_q + 1'b1;
            end else begin
              plane_q <= plane_q - 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan on a 4x2-pair, 2-plane geometry with a small sync RAM model.
// Double-buffer swap is exercised when LED_MATRIX_DBUF_EN is defined.
module tb_led_matrix_scan;
  localparam int COL_BITS   = 2;
  localparam int ROW_BITS   = 1;
  localparam int PWM_BITS   = 2;
  localparam int BASE_DELAY = 2;
`ifdef LED_MATRIX_DBUF_EN
  localparam int AW = 5;
`else
  localparam int AW = 4;
`endif

  logic          led_clk = 1'b0;
  logic          rsi_reset_n = 1'b0;
  logic          enable = 1'b0;
`ifdef LED_MATRIX_DBUF_EN
  logic          buf_sel = 1'b0;
`endif
  logic [AW-1:0] mem_addr;
  logic [5:0]    mem_rdata;
  logic [0:0]    demux;
  logic [2:0]    rgb0;
  logic [2:0]    rgb1;
  logic          rgb_clk;
  logic          rgb_stb;
  logic          oe_n;
  logic          frame_start;

  led_matrix_scan #(
    .COL_BITS   (COL_BITS),
    .ROW_BITS   (ROW_BITS),
    .PWM_BITS   (PWM_BITS),
    .BASE_DELAY (BASE_DELAY)
  ) dut (
    .led_clk     (led_clk),
    .rsi_reset_n (rsi_reset_n),
    .enable      (enable),
`ifdef LED_MATRIX_DBUF_EN
    .buf_sel     (buf_sel),
`endif
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .demux       (demux),
    .rgb0        (rgb0),
    .rgb1        (rgb1),
    .rgb_clk     (rgb_clk),
    .rgb_stb     (rgb_stb),
    .oe_n        (oe_n),
    .frame_start (frame_start)
  );

  always #5 led_clk = ~led_clk;

  logic [5:0] ram [0:(1<<AW)-1];
  always @(posedge led_clk) mem_rdata <= ram[mem_addr];

  typedef struct {
    int         row;
    int         col;
    logic [5:0] top;
    logic [5:0] bot;
    logic [2:0] exp0;
    logic [2:0] exp1;
  } vec_t;

  vec_t vecs [16];
  int   n_tests = 0;
  int   n_fail  = 0;

  int stb_t [$];
  int oe_start [$];
  int oe_len [$];
  int fs_t [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge led_clk);
    #3;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int clk_cnt;
    int oe_cnt;
    int stb_cnt;
    int k;
    logic prev_oe;
    logic prev_stb;
    logic [0:0] prev_demux;
    int exp_stb [4];
    int exp_oes [4];
    int exp_oel [4];

    exp_stb = '{17, 39, 59, 81};
    exp_oes = '{18, 40, 60, 82};
    exp_oel = '{4, 2, 4, 2};

    // Scan order: row0 plane1, row0 plane0, row1 plane1, row1 plane0; pixel bits {R[1:0],G[1:0],B[1:0]}.
    vecs[0]  = '{0, 0, 6'b100111, 6'b000001, 3'b101, 3'b000};
    vecs[1]  = '{0, 1, 6'b011000, 6'b100000, 3'b010, 3'b100};
    vecs[2]  = '{0, 2, 6'b110010, 6'b001000, 3'b101, 3'b010};
    vecs[3]  = '{0, 3, 6'b001101, 6'b110110, 3'b010, 3'b101};
    vecs[4]  = '{0, 0, 6'b100111, 6'b000001, 3'b011, 3'b001};
    vecs[5]  = '{0, 1, 6'b011000, 6'b100000, 3'b100, 3'b000};
    vecs[6]  = '{0, 2, 6'b110010, 6'b001000, 3'b100, 3'b000};
    vecs[7]  = '{0, 3, 6'b001101, 6'b110110, 3'b011, 3'b110};
    vecs[8]  = '{1, 0, 6'b111111, 6'b011011, 3'b111, 3'b011};
    vecs[9]  = '{1, 1, 6'b000000, 6'b111001, 3'b000, 3'b110};
    vecs[10] = '{1, 2, 6'b101010, 6'b000100, 3'b111, 3'b000};
    vecs[11] = '{1, 3, 6'b010101, 6'b101110, 3'b000, 3'b111};
    vecs[12] = '{1, 0, 6'b111111, 6'b011011, 3'b111, 3'b101};
    vecs[13] = '{1, 1, 6'b000000, 6'b111001, 3'b000, 3'b101};
    vecs[14] = '{1, 2, 6'b101010, 6'b000100, 3'b000, 3'b010};
    vecs[15] = '{1, 3, 6'b010101, 6'b101110, 3'b111, 3'b010};

    for (int i = 0; i < (1 << AW); i++) ram[i] = 6'h00;
    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < (1 << (AW - 4)); b++) begin
        ram[b*16 + vecs[i].row*4 + vecs[i].col]     = vecs[i].top;
        ram[b*16 + 8 + vecs[i].row*4 + vecs[i].col] = vecs[i].bot;
      end
    end

    // Reset state, with enable already high.
    enable      = 1'b1;
    rsi_reset_n = 1'b0;
    repeat (3) step();
    check("rst_oe_n", oe_n, 1);
    check("rst_rgb_clk", rgb_clk, 0);
    check("rst_rgb_stb", rgb_stb, 0);
    check("rst_demux", demux, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_rgb0", rgb0, 0);
    check("rst_rgb1", rgb1, 0);

    rsi_reset_n = 1'b1;
    #1;
    check("first_idle_frame_start", frame_start, 1);

    // Frame 1: pixel bits per plane at every rgb_clk pulse.
    for (int i = 0; i < 16; i++) begin
      n = 0;
      while (rgb_clk !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      check($sformatf("vec%0d_rgb_clk_seen", i), rgb_clk, 1);
      check($sformatf("vec%0d_rgb0", i), rgb0, vecs[i].exp0);
      check($sformatf("vec%0d_rgb1", i), rgb1, vecs[i].exp1);
      step();
    end

    n = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("frame2_start_seen", frame_start, 1);

    // Frame 2: cycle-accurate timing of strobes, OE windows and row select.
    clk_cnt    = 0;
    prev_oe    = 1'b1;
    prev_stb   = 1'b0;
    prev_demux = demux;
    for (int t = 0; t <= 84; t++) begin
      if (rgb_clk) clk_cnt++;
      if (rgb_stb) stb_t.push_back(t);
      if (frame_start) fs_t.push_back(t);
      if (!oe_n && prev_oe) begin
        oe_start.push_back(t);
        oe_len.push_back(0);
      end
      if (!oe_n) oe_len[oe_len.size()-1]++;
      if (demux != prev_demux) check($sformatf("demux_change_t%0d_after_latch", t), prev_stb, 1);
      if (t == 58) check("demux_row0_t58", demux, 0);
      if (t == 60) check("demux_row1_t60", demux, 1);
      prev_oe    = oe_n;
      prev_stb   = rgb_stb;
      prev_demux = demux;
      if (t < 84) step();
    end
    check("frame_rgb_clk_count", clk_cnt, 16);
    check("frame_stb_count", stb_t.size(), 4);
    check("frame_oe_runs", oe_start.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stb%0d_cycle", i), (i < stb_t.size()) ? stb_t[i] : -1, exp_stb[i]);
      check($sformatf("oe%0d_start", i), (i < oe_start.size()) ? oe_start[i] : -1, exp_oes[i]);
      check($sformatf("oe%0d_len", i), (i < oe_len.size()) ? oe_len[i] : -1, exp_oel[i]);
    end
    check("frame_start_count", fs_t.size(), 2);
    check("frame_start_period", (fs_t.size() == 2) ? (fs_t[1] - fs_t[0]) : -1, 84);

    // Enable dropped mid-column of plane 1: plane completes, then the panel stays dark.
    repeat (6) step();
    enable  = 1'b0;
    clk_cnt = 0;
    oe_cnt  = 0;
    stb_cnt = 0;
    for (int t = 0; t < 60; t++) begin
      if (rgb_clk) clk_cnt++;
      if (!oe_n) oe_cnt++;
      if (rgb_stb) stb_cnt++;
      step();
    end
    check("dis_remaining_clks", clk_cnt, 3);
    check("dis_latch_count", stb_cnt, 1);
    check("dis_oe_cycles_plane1", oe_cnt, 4);
    check("dis_idle_oe_n", oe_n, 1);
    check("dis_idle_frame_start", frame_start, 0);

    // Re-enable resumes at plane 0 of row 0 without a frame restart.
    enable = 1'b1;
    #1;
    check("reen_no_frame_start", frame_start, 0);
    k      = 0;
    oe_cnt = 0;
    for (int t = 0; t < 22; t++) begin
      if (rgb_clk) begin
        if (k < 4) begin
          check($sformatf("reen_col%0d_rgb0", k), rgb0, vecs[4+k].exp0);
          check($sformatf("reen_col%0d_rgb1", k), rgb1, vecs[4+k].exp1);
        end
        k++;
      end
      if (!oe_n) oe_cnt++;
      step();
    end
    check("reen_clk_count", k, 4);
    check("reen_oe_cycles_plane0", oe_cnt, 2);
    check("reen_demux_row0", demux, 0);

    // Asynchronous reset while row 1 is lit.
    n = 0;
    while (oe_n !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check("delay_reached", oe_n, 0);
    check("delay_demux_row1", demux, 1);
    rsi_reset_n = 1'b0;
    #1;
    check("arst_oe_n", oe_n, 1);
    check("arst_rgb_stb", rgb_stb, 0);
    check("arst_rgb_clk", rgb_clk, 0);
    check("arst_demux", demux, 0);
    step();
    step();
    rsi_reset_n = 1'b1;
    #1;
    check("post_arst_frame_start", frame_start, 1);

`ifdef LED_MATRIX_DBUF_EN
    // Buffer select toggled mid-frame takes effect only at the next frame start.
    repeat (10) step();
    buf_sel = 1'b1;
    n = 0;
    k = 0;
    while (frame_start !== 1'b1 && n < 200) begin
      if (mem_addr[AW-1] !== 1'b0) k++;
      step();
      n++;
    end
    check("dbuf_frame_start_seen", frame_start, 1);
    check("dbuf_msb_held_cycles", k, 0);
    step();
    check("dbuf_msb_after_swap", mem_addr[AW-1], 1);
    check("dbuf_half_after_swap", mem_addr[AW-2], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
